parity_frame_tx: RTL

PARITY_FRAME_TX -- requirements
Module: parity_frame_tx

---
 rtl/parity_frame_tx_pkg.sv | 15 +
 rtl/parity_frame_tx_baud_cnt.sv | 30 +++
 rtl/parity_frame_tx.sv | 107 ++++++++++
 3 files changed

// File: rtl/parity_frame_tx_pkg.sv
// Shared frame constants and FSM state encoding for the parity frame serialiser.
package parity_frame_tx_pkg;

    localparam int FRAME_BITS = 11;
    localparam int DATA_BITS  = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;

endpackage

// File: rtl/parity_frame_tx_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled, tick on the last count.
// Combinational tick, no backpressure; clr restarts the period so every frame is phase-aligned.
module parity_frame_tx_baud_cnt #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic arst_ni,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge arst_ni) begin
        if (!arst_ni) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/parity_frame_tx.sv
// Serialises a byte as start, 8 data bits LSB first, upstream parity, stop; tx low the cycle after accept.
// ready_o only in IDLE (one idle cycle between frames); PARITY_FRAME_TX_CHECK_EN adds a parity mismatch flag.
module parity_frame_tx
    import parity_frame_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       arst_ni,
    input  logic [7:0] data_i,
    input  logic       parity_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic       tx_o,
    output logic       busy_o,
    output logic       parity_err_o
);

    state_e                 state_q, state_d;
    logic [2:0]             bit_q, bit_d;
    logic [DATA_BITS-1:0]   data_q;
    logic                   par_q;
    logic                   tx_d;
    logic                   accept;
    logic                   tick;

    assign accept = valid_i && ready_o;

    parity_frame_tx_baud_cnt #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_cnt (
        .clk     (clk),
        .arst_ni (arst_ni),
        .clr     (accept),
        .en      (state_q != ST_IDLE),
        .tick    (tick)
    );

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        case (state_q)
            ST_IDLE:   if (accept) state_d = ST_START;
            ST_START:  if (tick)   state_d = ST_DATA;
            ST_DATA: begin
                if (tick) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'(DATA_BITS - 1)) state_d = ST_PARITY;
                end
            end
            ST_PARITY: if (tick)   state_d = ST_STOP;
            ST_STOP:   if (tick)   state_d = ST_IDLE;
            default:               state_d = ST_IDLE;
        endcase
    end

    // tx is registered from the next state so the start bit appears right after the accepting edge
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = data_q[bit_d];
            ST_PARITY: tx_d = par_q;
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q <= ST_IDLE;
            bit_q   <= 3'd0;
            data_q  <= '0;
            par_q   <= 1'b0;
            tx_o    <= 1'b1;
            ready_o <= 1'b0;
            busy_o  <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            if (accept) begin
                data_q <= data_i;
                par_q  <= parity_i;
            end
            tx_o    <= tx_d;
            ready_o <= (state_d == ST_IDLE);
            busy_o  <= (state_d != ST_IDLE);
        end
    end

`ifdef PARITY_FRAME_TX_CHECK_EN
    logic err_q;

    // Flag only; the frame still carries the upstream parity bit untouched
    always_ff @(posedge clk or negedge arst_ni) begin
        if (!arst_ni) begin
            err_q <= 1'b0;
        end else begin
            err_q <= accept && ((^data_i) != parity_i);
        end
    end

    assign parity_err_o = err_q;
`else
    assign parity_err_o = 1'b0;
`endif

endmodule
